// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the banked data memory.
//   - maskMode encodings (byte / half / word / illegal)
//   - FSM state encoding (IDLE, WAIT, RESP)
//   - latency bound and derived counter width
//   - request record latched on acceptance
package dmem_pkg;

    localparam logic [1:0] MASK_B   = 2'b00;
    localparam logic [1:0] MASK_H   = 2'b01;
    localparam logic [1:0] MASK_W   = 2'b10;
    localparam logic [1:0] MASK_BAD = 2'b11;

    localparam int unsigned LATENCY_MAX = 4;
    localparam int unsigned CNT_W       = $clog2(LATENCY_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_banked_if.sv
// dmem_banked_if: request/response bundle between the memory stage and
// the data memory.
//   master (requester): drives valid, addr, memRead, memWrite, maskMode,
//                       sext, writeData; observes ready, good, err, readData.
//   slave  (memory)   : the reverse.
interface dmem_banked_if;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  maskMode;
    logic        sext;
    logic [31:0] writeData;
    logic        good;
    logic        err;
    logic [31:0] readData;

    modport master (
        output valid, addr, memRead, memWrite, maskMode, sext, writeData,
        input  ready, good, err, readData
    );

    modport slave (
        input  valid, addr, memRead, memWrite, maskMode, sext, writeData,
        output ready, good, err, readData
    );

endinterface

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational lane handling for byte/half/word accesses.
//   mask_mode : access size (MASK_B / MASK_H / MASK_W / MASK_BAD)
//   lane      : addr[1:0] of the access
//   sext      : sign-extend byte/half loads
//   old_word  : current contents of the addressed word
//   wdata     : store data (low 8/16/32 bits used)
//   rdata     : extracted, extended load value
//   wword     : old_word with the selected lane bytes replaced
//   align_err : misaligned half/word access (only with DMEM_ALIGN_CHECK_EN)
// Build option: DMEM_ALIGN_CHECK_EN enables the alignment check; otherwise
// half uses addr[1] only and word ignores addr[1:0].
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  mask_mode,
    input  logic [1:0]  lane,
    input  logic        sext,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] wword,
    output logic        align_err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  be;
    logic [31:0] wrep;

    always_comb begin
        byte_v = 8'(old_word >> {lane, 3'b000});
        half_v = 16'(old_word >> {lane[1], 4'b0000});
        rdata  = '0;
        be     = '0;
        wrep   = wdata;
        wword  = old_word;

        case (mask_mode)
            MASK_B: begin
                rdata = {{24{sext & byte_v[7]}}, byte_v};
                be    = 4'b0001 << lane;
                wrep  = {4{wdata[7:0]}};
            end
            MASK_H: begin
                rdata = {{16{sext & half_v[15]}}, half_v};
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
            end
            MASK_W: begin
                rdata = old_word;
                be    = 4'b1111;
            end
            default: ;
        endcase

        // Data is replicated across all lanes so the byte enables alone pick it.
        for (int unsigned i = 0; i < 4; i++) begin
            wword[8*i +: 8] = be[i] ? wrep[8*i +: 8] : old_word[8*i +: 8];
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        align_err = ((mask_mode == MASK_H) && lane[0]) ||
                    ((mask_mode == MASK_W) && (lane != 2'b00));
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: word-organised data RAM behind a valid/ready request and a
// single-cycle good response, with configurable response latency.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : dmem_banked_if.slave (request fields, ready, good, err, readData)
// Parameters: DEPTH (32-bit words, power of two), LATENCY (1..LATENCY_MAX).
// Build option: DMEM_ALIGN_CHECK_EN (see dmem_lane_unit) flags misaligned
// half/word accesses as errors.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    dmem_banked_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem [DEPTH];

    dmem_req_t        req_in;
    dmem_req_t        req_sel;
    logic             ready;
    logic             accept;
    logic             enter_resp;
    logic             req_err;
    logic             high_nz;
    logic             mem_we;
    logic [AW-1:0]    word_idx;
    logic [31:0]      old_word;
    logic [31:0]      lane_rdata;
    logic [31:0]      lane_wword;
    logic             align_err;

    assign req_in = '{
        addr:  bus.addr,
        rd:    bus.memRead,
        wr:    bus.memWrite,
        mask:  bus.maskMode,
        sext:  bus.sext,
        wdata: bus.writeData
    };

    assign ready  = (state_q != WAIT);
    assign accept = bus.valid & ready;

    // With LATENCY = 1 the accept edge is also the edge entering RESP, so the
    // array is accessed with the live request rather than the latched copy.
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    assign req_sel    = (state_q == WAIT) ? req_q : req_in;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    req_d   = req_in;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------ datapath
    assign word_idx = req_sel.addr[AW+1:2];
    assign high_nz  = ((req_sel.addr >> (AW + 2)) != '0);
    assign old_word = mem[word_idx];

    dmem_lane_unit u_lane (
        .mask_mode (req_sel.mask),
        .lane      (req_sel.addr[1:0]),
        .sext      (req_sel.sext),
        .old_word  (old_word),
        .wdata     (req_sel.wdata),
        .rdata     (lane_rdata),
        .wword     (lane_wword),
        .align_err (align_err)
    );

    always_comb begin
        req_err = (req_sel.rd & req_sel.wr) |
                  ~(req_sel.rd | req_sel.wr) |
                  (req_sel.mask == MASK_BAD) |
                  high_nz |
                  align_err;

        rdata_d = '0;
        err_d   = 1'b0;
        if (enter_resp) begin
            err_d = req_err;
            if (!req_err && req_sel.rd) begin
                rdata_d = lane_rdata;
            end
        end

        mem_we = enter_resp & ~req_err & req_sel.wr & reset;
    end

    // The array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= lane_wword;
        end
    end

    assign bus.ready    = ready;
    assign bus.good     = (state_q == RESP);
    assign bus.err      = err_q;
    assign bus.readData = rdata_q;

endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: directed, table-driven bench for dmem_banked. Two
// instances share clock and reset: u_dut0 with LATENCY = 1, u_dut1 with
// LATENCY = 3. Expected values are hand-computed in the vector table.
module tb_dmem_banked;
    import dmem_pkg::*;

    logic clk;
    logic reset;

    dmem_banked_if if0 ();
    dmem_banked_if if1 ();

    dmem_banked #(.DEPTH(256), .LATENCY(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    dmem_banked #(.DEPTH(256), .LATENCY(3)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        bit          sel;
        bit          rd;
        bit          wr;
        logic [1:0]  mask;
        bit          sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit sel, input bit rd, input bit wr, input logic [1:0] mask,
                                input bit sext, input logic [31:0] addr, input logic [31:0] wdata,
                                input bit eerr, input logic [31:0] erd);
        vec_t v;
        v.sel = sel; v.rd = rd; v.wr = wr; v.mask = mask; v.sext = sext;
        v.addr = addr; v.wdata = wdata; v.eerr = eerr; v.erd = erd;
        return v;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? if1.ready : if0.ready;
    endfunction

    function automatic logic gd(input bit sel);
        return sel ? if1.good : if0.good;
    endfunction

    task automatic drive(input bit sel, input logic vld, input vec_t v);
        if (!sel) begin
            if0.valid = vld; if0.addr = v.addr; if0.memRead = v.rd; if0.memWrite = v.wr;
            if0.maskMode = v.mask; if0.sext = v.sext; if0.writeData = v.wdata;
        end else begin
            if1.valid = vld; if1.addr = v.addr; if1.memRead = v.rd; if1.memWrite = v.wr;
            if1.maskMode = v.mask; if1.sext = v.sext; if1.writeData = v.wdata;
        end
    endtask

    // Called #1 after a rising edge; consecutive calls are back-to-back.
    task automatic do_req(input vec_t v, input int unsigned lat, input int idx,
                          output logic [31:0] rd_o, output logic err_o);
        int unsigned cyc;
        chk($sformatf("ready_at_req_v%0d", idx), {31'b0, rdy(v.sel)}, 32'd1);
        drive(v.sel, 1'b1, v);
        @(posedge clk); #1;
        drive(v.sel, 1'b0, v);
        cyc = 1;
        while (!gd(v.sel) && cyc < 12) begin
            chk($sformatf("ready_in_wait_v%0d", idx), {31'b0, rdy(v.sel)}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("latency_v%0d", idx), cyc, lat);
        rd_o  = v.sel ? if1.readData : if0.readData;
        err_o = v.sel ? if1.err : if0.err;
    endtask

    task automatic chk_idle(input bit sel, input string tag);
        chk($sformatf("%s_ready_dut%0d", tag, sel), {31'b0, rdy(sel)}, 32'd1);
        chk($sformatf("%s_good_dut%0d", tag, sel), {31'b0, gd(sel)}, 32'd0);
        chk($sformatf("%s_err_dut%0d", tag, sel), {31'b0, sel ? if1.err : if0.err}, 32'd0);
        chk($sformatf("%s_rdata_dut%0d", tag, sel), sel ? if1.readData : if0.readData, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        vec_t        v;
        int unsigned k;

        // sel rd wr mask sext addr wdata eerr erd
        vecs.push_back(mk(0, 0, 1, MASK_W, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, MASK_W, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 1, MASK_B, 0, 32'h13, 32'h00000080, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, MASK_B, 1, 32'h13, 32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 1, 0, MASK_B, 0, 32'h13, 32'h0,        0, 32'h00000080));
        vecs.push_back(mk(0, 1, 0, MASK_W, 0, 32'h10, 32'h0,        0, 32'h80ADBEEF));
        vecs.push_back(mk(0, 1, 0, MASK_H, 1, 32'h12, 32'h0,        0, 32'hFFFF80AD));
        vecs.push_back(mk(0, 0, 1, MASK_H, 0, 32'h10, 32'h12345678, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, MASK_B, 1, 32'h11, 32'h0,        0, 32'h00000056));
        vecs.push_back(mk(0, 1, 0, MASK_W, 0, 32'h10, 32'h0,        0, 32'h80AD5678));
        vecs.push_back(mk(0, 0, 1, MASK_W, 0, 32'h00, 32'hA5A5A5A5, 0, 32'h0));
        // error cases, none may touch the array
        vecs.push_back(mk(0, 1, 1, MASK_W, 0, 32'h10, 32'h11111111, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, MASK_W, 0, 32'h10, 32'h22222222, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, MASK_BAD, 0, 32'h10, 32'h33333333, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, MASK_BAD, 0, 32'h10, 32'h0,      1, 32'h0));
        vecs.push_back(mk(0, 0, 1, MASK_W, 0, 32'h400, 32'hFFFFFFFF, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, MASK_W, 0, 32'h400, 32'h0,       1, 32'h0));
        vecs.push_back(mk(0, 1, 0, MASK_W, 0, 32'h10, 32'h0,        0, 32'h80AD5678));
        vecs.push_back(mk(0, 1, 0, MASK_W, 0, 32'h00, 32'h0,        0, 32'hA5A5A5A5));
        // half load from odd address
        vecs.push_back(mk(0, 0, 1, MASK_W, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0));
`ifdef DMEM_ALIGN_CHECK_EN
        vecs.push_back(mk(0, 1, 0, MASK_H, 0, 32'h21, 32'h0,        1, 32'h0));
`else
        vecs.push_back(mk(0, 1, 0, MASK_H, 0, 32'h21, 32'h0,        0, 32'h0000F00D));
`endif
        // LATENCY = 3 instance: store/load back-to-back
        vecs.push_back(mk(1, 0, 1, MASK_W, 0, 32'h20, 32'h11223344, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, MASK_W, 0, 32'h20, 32'h0,        0, 32'h11223344));

        v = mk(0, 0, 0, MASK_W, 0, 32'h0, 32'h0, 0, 32'h0);
        drive(1'b0, 1'b0, v);
        drive(1'b1, 1'b0, v);

        reset = 1'b0;
        #23;
        chk_idle(1'b0, "in_reset");
        chk_idle(1'b1, "in_reset");
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle(1'b0, "post_reset");
        chk_idle(1'b1, "post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i], vecs[i].sel ? 3 : 1, i, r, e);
            chk($sformatf("err_v%0d", i), {31'b0, e}, {31'b0, vecs[i].eerr});
            chk($sformatf("rdata_v%0d", i), r, vecs[i].erd);
        end

        // good lasts exactly one cycle when no new request follows
        @(posedge clk); #1;
        chk_idle(1'b1, "after_resp");

        // Reset during WAIT on the LATENCY = 3 instance: the store is dropped.
        v = mk(1, 0, 1, MASK_W, 0, 32'h20, 32'h99999999, 0, 32'h0);
        drive(1'b1, 1'b1, v);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, v);
        chk("rst_wait_ready_before", {31'b0, rdy(1'b1)}, 32'd0);
        #2;
        reset = 1'b0;
        #2;
        chk_idle(1'b1, "rst_wait_asserted");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle(1'b1, "rst_wait_released");
        k = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (gd(1'b1)) k++;
        end
        chk("rst_wait_no_good", k, 32'd0);
        v = mk(1, 1, 0, MASK_W, 0, 32'h20, 32'h0, 0, 32'h11223344);
        do_req(v, 3, 100, r, e);
        chk("rst_wait_err", {31'b0, e}, 32'd0);
        chk("rst_wait_old_data", r, 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised successor to the single-cycle data memory: a word-organised data RAM with a request/response handshake, configurable response latency, byte/half/word lane access with optional sign extension, and explicit error reporting. It sits between the core's memory stage and the data array, replacing the combinational read path with a registered, state-machine-driven one so that the memory stage can tolerate multi-cycle data access.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, 16..65536.
- LATENCY, 1: cycles from request acceptance to `good`; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it (0) resets immediately, release is synchronous to `clk`.
- valid  in  1  request present.
- ready  out  1  block can accept a request this cycle.
- addr  in  32  byte address.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- maskMode  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sext  in  1  sign-extend byte/half loads.
- writeData  in  32  store data; low 8/16/32 bits used per maskMode.
- good  out  1  response valid, exactly one cycle per accepted request.
- err  out  1  request failed; qualified by `good`.
- readData  out  32  load result; qualified by `good`.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- Accept = valid & ready. ready = 1 in IDLE and RESP, 0 in WAIT.
- On accept: latch addr, memRead, memWrite, maskMode, sext, writeData; counter loads LATENCY-1. If LATENCY = 1, next state RESP; else WAIT.
- WAIT: decrement counter each cycle; at counter = 1, next state RESP.
- RESP: good = 1. Next state RESP if a new request is accepted with LATENCY = 1, WAIT if accepted with LATENCY > 1, else IDLE.
- Array access (read sample and write commit) happens on the edge entering RESP; readData/err are registered on that same edge.
- Word index = addr[log2(DEPTH)+1:2]. Byte lane = addr[1:0]; half lane = addr[1].
- Load: byte/half extracted from the selected lane, upper bits = sext & lane MSB, else 0. Word: full word.
- Store: only the selected lane's bytes change; other bytes keep their value.
- Error (err = 1, no array change, readData = 0): memRead & memWrite; neither set; maskMode = 11; addr[31:log2(DEPTH)+2] nonzero.
- readData = 0 and err = 0 whenever good = 0.
- The array is not reset; contents are undefined until written.

## Timing
- Reset values: ready = 1, good = 0, err = 0, readData = 0; state IDLE; counter 0.
- Latency: request accepted at edge N → good high in the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- Throughput: one request per LATENCY cycles, back-to-back via acceptance in RESP.
- Store then load of the same address back-to-back: the load returns the new data, because the store commits before the load samples.
- No backpressure on the response; the requester must take `good` in its cycle.
- Reset asserted during WAIT: the latched request is discarded, and a pending store is never committed. Reset asserted in the cycle of the commit edge: the commit is not guaranteed.
- valid while ready = 0 is ignored; the requester holds the request.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 00, sets err = 1, performs no write and returns readData = 0.
- DMEM_ALIGN_CHECK_EN undefined: the low address bits are ignored for alignment. Half uses addr[1] only; word ignores addr[1:0]. This is legacy-compatible.

## Structure
- Package `dmem_pkg`: maskMode constants MASK_B = 2'b00, MASK_H = 2'b01, MASK_W = 2'b10, MASK_BAD = 2'b11; state encoding IDLE/WAIT/RESP; `LATENCY_MAX = 4`.
- Sub-module `dmem_lane_unit` (combinational) holds the read extract/sign-extend and write-merge by maskMode and addr[1:0]. The top level holds the FSM, counter, request latch and array.

## Test plan
- Reset then word store 0xDEADBEEF to 0x10, then word load from 0x10, with LATENCY = 1 → each good is one cycle after acceptance, err = 0, load returns 0xDEADBEEF.
- Byte store 0x80 to 0x13, then byte load from 0x13 with sext = 1 and with sext = 0 → 0xFFFFFF80 / 0x00000080; word at 0x10 = 0x80ADBEEF.
- LATENCY = 3: store/load back-to-back to 0x20 → ready = 0 for two WAIT cycles; good three cycles after each acceptance; load returns the stored data.
- memRead = memWrite = 1, maskMode = 11, and addr = 0x0000_0400 with DEPTH = 256 → each gives good with err = 1, readData = 0, and no array change.
- Half load from 0x21 → with DMEM_ALIGN_CHECK_EN: err = 1; without: returns the lane for addr[1] = 0, err = 0.
- Store accepted, then reset pulled low during WAIT (LATENCY = 3) → after reset: ready = 1, good = 0, and a read of that address shows the old data.
